// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings and helpers for the decode stage.
// Holds the instruction classes, memory-access codes, the decoded-control
// bundle and the 8-bit sign-extension helper.
package decode_pkg;

  // Instruction class carried in command[15:14]
  typedef enum logic [1:0] {
    CLS_LOAD  = 2'd0,
    CLS_STORE = 2'd1,
    CLS_LDI   = 2'd2,
    CLS_ALU   = 2'd3
  } cls_e;

  // Memory access request presented downstream
  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_RD   = 2'b01,
    MEM_WR   = 2'b10
  } mem_e;

  localparam int NUM_REGS = 8;

  // Width of the sign-extension helper result; callers truncate with a
  // size cast, so DATA_W may be anything from 16 up to this value.
  localparam int SEXT_W = 64;

  // Control fields derived from the command word alone
  typedef struct packed {
    logic [2:0] src_a;     // register behind alu1 / storedata
    logic [2:0] src_b;     // register behind alu2 / address base
    logic       use_a;     // src_a is a true dependency
    logic       use_b;     // src_b is a true dependency
    logic [2:0] dest;      // destination register
    logic       writereg;  // instruction produces a register result
    mem_e       memwrite;  // memory access kind
  } dec_t;

  // Sign-extend an 8-bit displacement
  function automatic logic [SEXT_W-1:0] sext8(input logic [7:0] d8);
    return {{(SEXT_W-8){d8[7]}}, d8};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 8-entry register file with three combinational read ports
// and one write port.
// Build option: DECODE_STAGE_BYPASS_EN forwards a same-cycle write to every
// read port; without it a read returns the value held before the write.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int INIT_IDX = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  input  logic [2:0]        raddr_c,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage: reset to index or zero, otherwise single write port
  // NOTE: this array is reset because software relies on defined initial
  // contents; at eight entries it stays a flop array, not a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports, optionally forwarding the write issued in the same cycle
  // NOTE: every output gets its default first so no path leaves a latch.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    rdata_c = regs[raddr_c];
`ifdef DECODE_STAGE_BYPASS_EN
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr == raddr_b)) rdata_b = wdata;
    if (we && (waddr == raddr_c)) rdata_c = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes a 16-bit command, reads operands, tracks in-flight
// register results with a pending scoreboard and presents a registered
// bundle through a valid/ready handshake.
// Build option: DECODE_STAGE_BYPASS_EN lets a same-cycle writeback release
// a hazard and forwards writeval into the operands; undefined, the hazard
// comes from the registered scoreboard and issue follows one cycle later.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int INIT_IDX = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       command,
  input  logic [15:0]       pc,
  input  logic              writeflag,
  input  logic [2:0]        writetarget,
  input  logic [DATA_W-1:0] writeval,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu1,
  output logic [DATA_W-1:0] alu2,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] storedata,
  output logic              writereg,
  output logic [1:0]        memwrite,
  output logic [2:0]        regaddress,
  output logic [3:0]        opcode,
  output logic [15:0]       out_pc
);

  cls_e              cls;
  dec_t              dec;
  logic [7:0]        pending;
  logic [7:0]        pend_eff;
  logic [7:0]        clr_mask;
  logic [7:0]        set_mask;
  logic              wb_en;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] sext_d8;
  logic [DATA_W-1:0] addr_next;
  logic [DATA_W-1:0] sd_next;

  assign cls = cls_e'(command[15:14]);

  // Command decode: operand selectors, dependencies, destination, mem kind
  always_comb begin
    dec.src_a    = 3'd0;
    dec.src_b    = 3'd0;
    dec.use_a    = 1'b0;
    dec.use_b    = 1'b0;
    dec.dest     = 3'd0;
    dec.writereg = 1'b0;
    dec.memwrite = MEM_NONE;
    case (cls)
      CLS_ALU: begin
        dec.src_a    = command[13:11];
        dec.src_b    = (command[7:4] <= 4'd8) ? command[10:8] : command[2:0];
        dec.use_a    = 1'b1;
        dec.use_b    = 1'b1;
        dec.dest     = command[10:8];
        dec.writereg = 1'b1;
      end
      CLS_LOAD: begin
        // alu1 still shows R[13:11], but only the base register gates issue
        dec.src_a    = command[13:11];
        dec.src_b    = command[10:8];
        dec.use_b    = 1'b1;
        dec.dest     = command[13:11];
        dec.writereg = 1'b1;
        dec.memwrite = MEM_RD;
      end
      CLS_STORE: begin
        dec.src_a    = command[13:11];
        dec.src_b    = command[10:8];
        dec.use_a    = 1'b1;
        dec.use_b    = 1'b1;
        dec.memwrite = MEM_WR;
      end
      CLS_LDI: begin
        // Both read ports stay on R0; the immediate travels on address
        dec.dest     = command[10:8];
        dec.writereg = 1'b1;
        dec.memwrite = MEM_RD;
      end
      default: ;
    endcase
  end

  decode_regfile #(
    .DATA_W   (DATA_W),
    .INIT_IDX (INIT_IDX)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (writetarget),
    .wdata   (writeval),
    .raddr_a (dec.src_a),
    .raddr_b (dec.src_b),
    .raddr_c (command[13:11]),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rdata_c (rdata_c)
  );

  // Writeback is ignored while reset is high
  assign wb_en    = writeflag && !reset;
  assign clr_mask = wb_en ? (8'd1 << writetarget) : 8'd0;

`ifdef DECODE_STAGE_BYPASS_EN
  assign pend_eff = pending & ~clr_mask;
`else
  assign pend_eff = pending;
`endif

  // Hazard: any real source or the destination is still awaiting writeback
  always_comb begin
    hazard = (dec.use_a    && pend_eff[dec.src_a]) ||
             (dec.use_b    && pend_eff[dec.src_b]) ||
             (dec.writereg && pend_eff[dec.dest]);
  end

  assign in_ready = !reset && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign set_mask = (accept && dec.writereg) ? (8'd1 << dec.dest) : 8'd0;

  // Next address and store data; the sum wraps at DATA_W bits
  always_comb begin
    sext_d8   = DATA_W'(sext8(command[7:0]));
    addr_next = '0;
    sd_next   = '0;
    case (cls)
      CLS_LOAD:  addr_next = rdata_b + sext_d8;
      CLS_STORE: begin
        addr_next = rdata_b + sext_d8;
        sd_next   = rdata_c;
      end
      CLS_LDI:   addr_next = sext_d8;
      default: ;
    endcase
  end

  // Scoreboard: writeback clears, a same-cycle issue to that register wins
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // Output bundle: load on accept, hold while stalled, retire on out_ready
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu1       <= '0;
      alu2       <= '0;
      address    <= '0;
      storedata  <= '0;
      writereg   <= 1'b0;
      memwrite   <= MEM_NONE;
      regaddress <= 3'd0;
      opcode     <= 4'd0;
      out_pc     <= 16'd0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu1       <= rdata_a;
      alu2       <= rdata_b;
      address    <= addr_next;
      storedata  <= sd_next;
      writereg   <= dec.writereg;
      memwrite   <= dec.memwrite;
      regaddress <= dec.writereg ? dec.dest : 3'd0;
      opcode     <= command[7:4];
      out_pc     <= pc;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16 (legal >=16), the register, operand and address width.
REQ-002 SHALL have parameter INIT_IDX, default 1; 1 = register i resets to value i, 0 = all registers reset to zero.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, command in 16, pc in 16 (instruction handshake).
REQ-006 SHALL have ports writeflag in 1, writetarget in 3, writeval in DATA_W (writeback port, no handshake).
REQ-007 SHALL have ports out_valid out 1, out_ready in 1 (decoded-bundle handshake).
REQ-008 SHALL have outputs alu1, alu2, address, storedata (DATA_W each), writereg 1, memwrite 2, regaddress 3, opcode 4, out_pc 16, all registered.

Function
REQ-009 SHALL hold 8 registers of DATA_W bits, two read ports plus storedata read, one write port driven by writeflag/writetarget/writeval.
REQ-010 SHALL decode class=command[15:14]: class 3 ALU: src1=[13:11], src2=[10:8] if [7:4]<=8 else [2:0], dest=[10:8], writereg=1, memwrite=00.
REQ-011 SHALL decode class 0 load: alu1=R[13:11], alu2=R[10:8], address=R[10:8]+sext(d8), dest=[13:11], writereg=1, memwrite=01; dependency on [10:8] only.
REQ-012 SHALL decode class 1 store: alu1=R[13:11], alu2=R[10:8], address=R[10:8]+sext(d8), storedata=R[13:11], writereg=0, memwrite=10, regaddress=0.
REQ-013 SHALL decode class 2 load-immediate: no sources, alu1=alu2=R0, address=sext(d8), dest=[10:8], writereg=1, memwrite=01.
REQ-014 SHALL set opcode=command[7:4], out_pc=pc, storedata=0 for classes other than 1; d8=command[7:0], sext to DATA_W; address sum wraps modulo 2^DATA_W.
REQ-015 SHALL keep an 8-bit pending scoreboard: bit dest set on accept of any writereg=1 instruction; bit writetarget cleared when writeflag=1.
REQ-016 SHALL give set priority over clear when accept and writeback target the same register in one cycle.
REQ-017 SHALL flag hazard when any dependency source or the dest of the incoming command has its pending bit set.
REQ-018 SHALL drive in_ready = !hazard && (!out_valid || out_ready), combinationally; accept = in_valid && in_ready.
REQ-019 SHALL on accept load all outputs and set out_valid=1 in the next cycle (latency 1); on out_ready without accept clear out_valid.
REQ-020 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL accept writeback regardless of handshake state; writeback to a non-pending register updates the register, scoreboard unchanged.

Reset
REQ-022 SHALL on reset: out_valid=0, scoreboard=0, registers per INIT_IDX, all data outputs 0, memwrite=00, writereg=0; writeflag ignored during reset.
REQ-023 SHALL drop any held bundle when reset asserts mid-operation; in_ready=0 while reset is high.

Configuration
REQ-024 SHALL honour macro DECODE_STAGE_BYPASS_EN: defined = same-cycle writeback clears hazard and writeval is forwarded to alu1/alu2/storedata/address; undefined = hazard from registered scoreboard, register read returns pre-write value, issue one cycle after writeback.

Structure
REQ-025 SHALL place class encodings (ALU=3, LOAD=0, STORE=1, LDI=2), memwrite codes (NONE=00, RD=01, WR=10) and sext function in shared package decode_pkg.
REQ-026 SHALL implement register file plus bypass as sub-module decode_regfile; scoreboard and handshake stay in decode_stage.

Verification
REQ-027 SHALL verify reset, INIT_IDX=1: command 0xD320 (ALU, [7:4]=2) -> next cycle alu1=2, alu2=3, regaddress=3, writereg=1, memwrite=00.
REQ-028 SHALL verify store 0x53FE -> alu1=2, storedata=2, address=3+0xFFFE=0x0001, memwrite=10, writereg=0.
REQ-029 SHALL verify RAW: accept ALU dest r3, then ALU reading r3 -> in_ready=0 until writeflag=1, writetarget=3, writeval=0x00AA; bypass build issues same cycle with alu2=0x00AA, non-bypass one cycle later.
REQ-030 SHALL verify backpressure: out_ready=0 for 3 cycles -> outputs constant, in_ready=0, no scoreboard change; release -> next command accepted.
REQ-031 SHALL verify reset mid-stall: pending r5, assert reset -> out_valid=0, scoreboard clear, in_ready=1 first cycle after reset.
REQ-032 SHALL verify collision: accept writing r4 while writeback to r4 same cycle -> r4 stays pending, following reader of r4 stalls.
